// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in/serial-out transmitter with framing strobes
// Optional trailing even-parity bit when PISO_PARITY_BIT_EN is defined.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

`ifdef PISO_PARITY_BIT_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt, cnt_n, cnt_inc;
    logic             sout_n, sout_valid_n, frame_start_n, done_n, busy_n;
    logic             accept, first_bit, next_bit;
    logic [WIDTH-1:0] load_rest, sreg_rest;
`ifdef PISO_PARITY_BIT_EN
    logic             par, par_n;
`endif

    // done marks the last bit of the frame, so it doubles as the hand-over window
    assign load_ready = (state == IDLE) || ((state == SHIFT) && done);
    assign accept     = load_valid && load_ready;
    assign cnt_inc    = cnt + CW'(1);

    assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign load_rest = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
    assign next_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign sreg_rest = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    always_comb begin
        state_n       = state;
        sreg_n        = sreg;
        cnt_n         = cnt;
        sout_n        = sout;
        sout_valid_n  = sout_valid;
        frame_start_n = frame_start;
        done_n        = done;
        busy_n        = busy;
`ifdef PISO_PARITY_BIT_EN
        par_n         = par;
`endif
        if (accept) begin
            // new frame: first bit goes straight to sout, the rest waits in sreg
            state_n       = SHIFT;
            sreg_n        = load_rest;
            cnt_n         = '0;
            sout_n        = first_bit;
            sout_valid_n  = 1'b1;
            frame_start_n = 1'b1;
            done_n        = (LAST_IDX == '0);
            busy_n        = 1'b1;
`ifdef PISO_PARITY_BIT_EN
            par_n         = ^load_data;
`endif
        end else if (state == SHIFT) begin
            if (done) begin
                state_n       = IDLE;
                sreg_n        = '0;
                cnt_n         = '0;
                sout_n        = 1'b0;
                sout_valid_n  = 1'b0;
                frame_start_n = 1'b0;
                done_n        = 1'b0;
                busy_n        = 1'b0;
            end else begin
                cnt_n         = cnt_inc;
                sreg_n        = sreg_rest;
                sout_n        = next_bit;
                frame_start_n = 1'b0;
                done_n        = (cnt_inc == LAST_IDX);
`ifdef PISO_PARITY_BIT_EN
                if (cnt_inc == CW'(WIDTH)) begin
                    sout_n = par;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
`ifdef PISO_PARITY_BIT_EN
            par         <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            sreg        <= sreg_n;
            cnt         <= cnt_n;
            sout        <= sout_n;
            sout_valid  <= sout_valid_n;
            frame_start <= frame_start_n;
            done        <= done_n;
            busy        <= busy_n;
`ifdef PISO_PARITY_BIT_EN
            par         <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb/tb_piso_shift_tx.sv - scoreboard bench for piso_shift_tx, MSB-first and LSB-first instances
module tb_piso_shift_tx;
    localparam int WIDTH = 8;
`ifdef PISO_PARITY_BIT_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic load_ready_a, sout_a, sout_valid_a, frame_start_a, done_a, busy_a;
    logic load_ready_b, sout_b, sout_valid_b, frame_start_b, done_b, busy_b;

    int checks = 0;
    int failures = 0;
    logic [2:0] qa[$];
    logic [2:0] qb[$];

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_a), .sout(sout_a), .sout_valid(sout_valid_a),
        .frame_start(frame_start_a), .done(done_a), .busy(busy_a));

    piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_b), .sout(sout_b), .sout_valid(sout_valid_b),
        .frame_start(frame_start_b), .done(done_b), .busy(busy_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: each accepted word becomes FL entries {bit, frame_start, done}
    task automatic push_frame(input logic [WIDTH-1:0] w);
        for (int i = 0; i < FL; i++) begin
            logic ba, bb;
            ba = (i < WIDTH) ? w[WIDTH-1-i] : ^w;
            bb = (i < WIDTH) ? w[i] : ^w;
            qa.push_back({ba, (i == 0), (i == FL - 1)});
            qb.push_back({bb, (i == 0), (i == FL - 1)});
        end
    endtask

    always @(posedge clk) begin
        if (!rst && load_valid && load_ready_a) push_frame(load_data);
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst) begin
            chk("a_ready", 32'(load_ready_a), 32'(qa.size() <= 1));
            chk("a_busy", 32'(busy_a), 32'(qa.size() != 0));
            chk("a_valid", 32'(sout_valid_a), 32'(qa.size() != 0));
            e = (qa.size() != 0) ? qa.pop_front() : 3'b000;
            chk("a_sout", 32'(sout_a), 32'(e[2]));
            chk("a_frame_start", 32'(frame_start_a), 32'(e[1]));
            chk("a_done", 32'(done_a), 32'(e[0]));
            chk("b_ready", 32'(load_ready_b), 32'(qb.size() <= 1));
            chk("b_busy", 32'(busy_b), 32'(qb.size() != 0));
            chk("b_valid", 32'(sout_valid_b), 32'(qb.size() != 0));
            e = (qb.size() != 0) ? qb.pop_front() : 3'b000;
            chk("b_sout", 32'(sout_b), 32'(e[2]));
            chk("b_frame_start", 32'(frame_start_b), 32'(e[1]));
            chk("b_done", 32'(done_b), 32'(e[0]));
        end
    end

    task automatic chk_reset_values(input string nm);
        chk({nm, "_a"}, 32'({load_ready_a, sout_a, sout_valid_a, frame_start_a, done_a, busy_a}), 32'h20);
        chk({nm, "_b"}, 32'({load_ready_b, sout_b, sout_valid_b, frame_start_b, done_b, busy_b}), 32'h20);
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input bit hold);
        int t = 0;
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        while (!load_ready_a && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_timeout", 32'(load_ready_a), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) load_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(qa.size() + qb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("in_reset");
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_reset_values("idle");
        end
        @(posedge clk);
        #1;

        send(8'h1E, 1'b0);
        drain();

        // back-to-back FF then 00, with AA offered while not ready
        send(8'hFF, 1'b0);
        load_valid = 1'b1;
        load_data  = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        send(8'h00, 1'b0);
        drain();

        // asynchronous reset partway through bit 4
        send(8'hA5, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        chk_reset_values("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h3C, 1'b0);
        drain();

        send(8'h07, 1'b0);
        drain();
        send(8'h03, 1'b0);
        drain();

        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            send(WIDTH'($urandom), (gap == 0));
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        load_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in/serial-out transmitter built from D-type storage. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock on sout, with framing strobes. It is the transmit end of the team's serial bit link; the existing SIPO capture register is the receive end. It sits between a word-producing block and a single-wire data path.

Parameters:
WIDTH, 8, data word width in bits; legal range 1 to 32.
MSB_FIRST, 1, bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
clk  input  1  rising-edge clock; sole clock.
rst  input  1  asynchronous, active-high reset.
load_valid  input  1  producer has a word on load_data.
load_data  input  WIDTH  word to transmit.
load_ready  output  1  transmitter can accept a word this cycle.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a valid bit this cycle.
frame_start  output  1  sout carries the first bit of a frame.
done  output  1  sout carries the last bit of a frame.
busy  output  1  a frame is in progress.

Behaviour:
- The clock is clk. Reset is rst, which is asynchronous and active-high.
- Reset values: sout=0, sout_valid=0, frame_start=0, done=0, busy=0, load_ready=1. The shift register and bit counter are 0. State is IDLE.
- States:
  - IDLE: no frame in progress.
  - SHIFT: bits are being sent.
  - The bit counter is ceil(log2(WIDTH+2)) bits wide.
- Accept rule: a transfer occurs on a rising edge where load_valid=1 and load_ready=1. Only then is load_data captured.
- load_ready = (state==IDLE) or (state==SHIFT and current bit is the last bit of the frame). This gives back-to-back frames with no gap.
- Latency: for a word accepted at edge N, its first bit is on sout after edge N. All outputs are registered and valid in the cycle following edge N.
- Output timing in SHIFT:
  - One bit per cycle; sout_valid=1 and busy=1.
  - frame_start=1 only in the first-bit cycle.
  - done=1 only in the last-bit cycle.
  - For WIDTH=1, frame_start and done are both 1 in the same single cycle.
- Frame length is FRAME_LEN = WIDTH bits, or WIDTH+1 with the optional feature.
- SHIFT to IDLE: after the last-bit cycle, if no transfer occurred. Then sout=0 and sout_valid=busy=frame_start=done=0.
- SHIFT to SHIFT (new frame): a transfer in the last-bit cycle loads the new word. The new first bit follows immediately, with frame_start=1 and the counter reset.
- load_valid while load_ready=0 is ignored. The producer must hold load_valid and load_data until a transfer occurs. The in-flight frame is never modified.
- Changes to load_data outside a transfer edge have no effect.
- Reset asserted mid-frame immediately forces all reset values. The partial frame is discarded and is not resumed after reset is released.
- sout is 0 whenever sout_valid=0.

Optional Feature:
Macro: PISO_PARITY_BIT_EN.
- Defined:
  - One extra bit is appended after the data bits: even parity, the XOR of all WIDTH data bits of the captured word.
  - The parity is computed at capture.
  - done is asserted on the parity cycle, not the last data bit.
  - load_ready for back-to-back transfer rises on the parity cycle.
- Not defined:
  - Frames are exactly WIDTH bits.
  - No parity logic is present.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, release -> load_ready=1; sout=sout_valid=busy=frame_start=done=0 held for 5 idle cycles.
2. WIDTH=8, MSB_FIRST=1, transfer 8'h1E -> sout sequence 0,0,0,1,1,1,1,0 in 8 consecutive cycles starting the cycle after the accept edge. frame_start on bit 1 only, done on bit 8 only, then IDLE.
3. WIDTH=8, MSB_FIRST=0, transfer 8'h1E -> sout 0,1,1,1,1,0,0,0; frame_start and done as in case 2.
4. Back-to-back: hold load_valid=1 with 8'hFF, then 8'h00 presented during the done cycle -> 16 contiguous sout_valid cycles (eight 1s then eight 0s), two frame_start pulses, two done pulses. load_valid pulses for 8'hAA while load_ready=0 are ignored.
5. Mid-frame reset: transfer 8'hA5, assert rst asynchronously mid-cycle at bit 4 -> all outputs drop to reset values without waiting for a clock edge. After release, a new 8'h3C transfer sends 0,0,1,1,1,1,0,0 cleanly.
6. PISO_PARITY_BIT_EN defined, WIDTH=8, MSB_FIRST=1: 8'h07 -> 0,0,0,0,0,1,1,1 then parity bit 1 with done on the 9th bit. 8'h03 -> parity bit 0.
